// File: rtl/qpi_line_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : qpi_line_burst_master
// Purpose  : Initiator side of the QPI memory interface. Moves one cache line
//            (LINE_WORDS x 32 bit) per request between an internal line buffer
//            and a QPI memory responder. The client loads or reads the buffer
//            by word index, then requests a fill (read) or a writeback (write).
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            req_valid/ready/we  - request handshake; we=1 writeback, 0 fill
//            req_addr            - byte address, aligned down to a line
//            done, err           - completion pulse, timeout flag (with done)
//            buf_idx/we/wdata    - client buffer write port (IDLE only)
//            buf_rdata           - combinational read of buf[buf_idx]
//            qpi_*               - QPI responder side
// Options  : define QPI_BURST_TIMEOUT_EN to enable the burst stall watchdog
//            (TIMEOUT_CYCLES cycles without qpi_next_word aborts the burst).
// Revision : 1.0 - initial release
// ============================================================================
module qpi_line_burst_master #(
    parameter int LINE_WORDS     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [23:0]                   req_addr,
    output logic                          done,
    output logic                          err,
    input  logic [$clog2(LINE_WORDS)-1:0] buf_idx,
    input  logic                          buf_we,
    input  logic [31:0]                   buf_wdata,
    output logic [31:0]                   buf_rdata,
    output logic                          qpi_do_read,
    output logic                          qpi_do_write,
    output logic [23:0]                   qpi_addr,
    input  logic                          qpi_is_idle,
    output logic [31:0]                   qpi_wdata,
    input  logic [31:0]                   qpi_rdata,
    input  logic                          qpi_next_word
);

    localparam int          c_IDX_W     = $clog2(LINE_WORDS);
    localparam int          c_CNT_W     = c_IDX_W + 1;
    localparam logic [23:0] c_ADDR_MASK = ~24'((LINE_WORDS * 4) - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_IDLE = 2'd1;
    localparam logic [1:0] c_BURST     = 2'd2;
    localparam logic [1:0] c_DRAIN     = 2'd3;

    // Reject illegal configurations at elaboration.
    generate
        if ((LINE_WORDS < 2) || (LINE_WORDS > 32) ||
            ((LINE_WORDS & (LINE_WORDS - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
            $error("qpi_line_burst_master: illegal LINE_WORDS or TIMEOUT_CYCLES");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_we;
    logic [23:0]        r_addr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_buf [LINE_WORDS];

    logic w_accept;
    logic w_take;
    logic w_last_take;
    logic w_done;
    logic w_timeout;
    logic w_abort;

    // A word moves only in BURST; a watchdog abort cycle moves nothing.
    assign w_take      = (r_state == c_BURST) && qpi_next_word && !w_timeout;
    assign w_last_take = w_take && (r_cnt == c_CNT_W'(LINE_WORDS - 1));
    assign w_done      = (r_state == c_DRAIN) && qpi_is_idle;
    assign w_accept    = req_valid && req_ready;

    assign qpi_addr  = r_addr;
    assign qpi_wdata = r_buf[r_cnt[c_IDX_W-1:0]];
    assign buf_rdata = r_buf[buf_idx];

`ifdef QPI_BURST_TIMEOUT_EN
    localparam int c_STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_STALL_W-1:0] r_stall;
    logic                 r_abort;

    assign w_timeout = (r_state == c_BURST) && (r_stall == c_STALL_W'(TIMEOUT_CYCLES));
    assign w_abort   = r_abort;

    // Held at zero outside BURST, so entry into BURST always starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state != c_BURST) || qpi_next_word) begin
            r_stall <= '0;
        end else if (!w_timeout) begin
            r_stall <= r_stall + c_STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abort <= 1'b0;
        end else if (w_timeout) begin
            r_abort <= 1'b1;
        end else if (w_accept) begin
            r_abort <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_abort   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = c_WAIT_IDLE;
                end
            end
            c_WAIT_IDLE: begin
                if (qpi_is_idle) begin
                    w_state_nxt = c_BURST;
                end
            end
            c_BURST: begin
                if (w_last_take || w_timeout) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                // req_ready is already high in the done cycle, so a waiting
                // request is taken here without an extra IDLE cycle.
                if (qpi_is_idle) begin
                    w_state_nxt = req_valid ? c_WAIT_IDLE : c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        qpi_do_read  = 1'b0;
        qpi_do_write = 1'b0;
        case (r_state)
            c_IDLE: begin
                req_ready = 1'b1;
            end
            c_BURST: begin
                // Drop in the same cycle as the final word so the responder
                // never starts a ninth transfer.
                qpi_do_read  = !r_we && !w_last_take && !w_timeout;
                qpi_do_write =  r_we && !w_last_take && !w_timeout;
            end
            c_DRAIN: begin
                req_ready = w_done;
                done      = w_done;
                err       = w_done && w_abort;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, word counter, line buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_we   <= req_we;
                r_addr <= req_addr & c_ADDR_MASK;
                r_cnt  <= '0;
            end
            if (w_take) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if ((r_state == c_IDLE) && buf_we) begin
                r_buf[buf_idx] <= buf_wdata;
            end
            if (w_take && !r_we) begin
                r_buf[r_cnt[c_IDX_W-1:0]] <= qpi_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpi_line_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpi_line_burst_master
// Purpose  : Directed self-checking bench for qpi_line_burst_master. The QPI
//            responder is played directly from the stimulus sequence.
// Options  : QPI_BURST_TIMEOUT_EN adds the watchdog abort scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpi_line_burst_master;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [23:0] req_addr;
    logic        done, err;
    logic [2:0]  buf_idx;
    logic        buf_we;
    logic [31:0] buf_wdata, buf_rdata;
    logic        qpi_do_read, qpi_do_write;
    logic [23:0] qpi_addr;
    logic        qpi_is_idle;
    logic [31:0] qpi_wdata, qpi_rdata;
    logic        qpi_next_word;

    int total = 0;
    int bad   = 0;

    qpi_line_burst_master #(
        .LINE_WORDS     (LW),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .done          (done),
        .err           (err),
        .buf_idx       (buf_idx),
        .buf_we        (buf_we),
        .buf_wdata     (buf_wdata),
        .buf_rdata     (buf_rdata),
        .qpi_do_read   (qpi_do_read),
        .qpi_do_write  (qpi_do_write),
        .qpi_addr      (qpi_addr),
        .qpi_is_idle   (qpi_is_idle),
        .qpi_wdata     (qpi_wdata),
        .qpi_rdata     (qpi_rdata),
        .qpi_next_word (qpi_next_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        buf_idx = '0; buf_we = 1'b0; buf_wdata = '0;
        qpi_is_idle = 1'b1; qpi_rdata = '0; qpi_next_word = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        // ---------------- reset values ----------------
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_do_read", 32'(qpi_do_read), 32'd0);
        chk("rst_do_write", 32'(qpi_do_write), 32'd0);
        chk("rst_qpi_addr", 32'(qpi_addr), 32'd0);
        chk("rst_buf0", buf_rdata, 32'd0);

        // ---------------- 1: fill, next_word every cycle ----------------
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000104;
        #1 chk("t1_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t1_qpi_addr", 32'(qpi_addr), 32'h000100);
        chk("t1_ready_wait", 32'(req_ready), 32'd0);
        chk("t1_no_read_wait", 32'(qpi_do_read), 32'd0);
        tick();
        for (int i = 0; i < LW; i++) begin
            qpi_next_word = 1'b1; qpi_rdata = 32'hA0 + 32'(i);
            #1;
            chk("t1_do_read", 32'(qpi_do_read), (i < LW - 1) ? 32'd1 : 32'd0);
            chk("t1_done_burst", 32'(done), 32'd0);
            tick();
        end
        qpi_next_word = 1'b0;
        #1;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_ready_done", 32'(req_ready), 32'd1);
        tick();
        #1 chk("t1_done_once", 32'(done), 32'd0);
        for (int i = 0; i < LW; i++) begin
            buf_idx = 3'(i);
            #1 chk("t1_buf", buf_rdata, 32'hA0 + 32'(i));
        end

        // ---------------- 2: writeback, next_word every 3rd cycle ----------------
        buf_we = 1'b1;
        for (int i = 0; i < LW; i++) begin
            buf_idx = 3'(i); buf_wdata = 32'h10 + 32'(i);
            tick();
        end
        buf_we = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h00021F;
        tick();
        req_valid = 1'b0;
        #1 chk("t2_qpi_addr", 32'(qpi_addr), 32'h000200);
        tick();
        for (int i = 0; i < LW; i++) begin
            qpi_next_word = 1'b0;
            #1 chk("t2_do_write_stall", 32'(qpi_do_write), 32'd1);
            tick(); tick();
            qpi_next_word = 1'b1;
            #1;
            chk("t2_wdata", qpi_wdata, 32'h10 + 32'(i));
            chk("t2_do_write", 32'(qpi_do_write), (i < LW - 1) ? 32'd1 : 32'd0);
            chk("t2_no_read", 32'(qpi_do_read), 32'd0);
            tick();
        end
        qpi_next_word = 1'b0;
        #1 chk("t2_done", 32'(done), 32'd1);
        tick();

        // ---------------- 3: busy responder ----------------
        qpi_is_idle = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000300;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 chk("t3_hold_off", 32'(qpi_do_read | qpi_do_write), 32'd0);
            tick();
        end
        qpi_is_idle = 1'b1;
        tick();
        qpi_is_idle = 1'b0;
        #1 chk("t3_do_read_start", 32'(qpi_do_read), 32'd1);
        for (int i = 0; i < LW; i++) begin
            qpi_next_word = 1'b1; qpi_rdata = 32'h30 + 32'(i);
            tick();
        end
        qpi_next_word = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_drain_wait", 32'(done), 32'd0);
            tick();
        end
        qpi_is_idle = 1'b1;
        #1 chk("t3_done", 32'(done), 32'd1);
        tick();
        buf_idx = 3'd7;
        #1 chk("t3_buf7", buf_rdata, 32'h37);

        // ---------------- 4: buffer protection ----------------
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000400;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < LW; i++) begin
            qpi_next_word = 1'b1; qpi_rdata = 32'hB0 + 32'(i);
            if (i == 3) begin
                buf_we = 1'b1; buf_idx = 3'd2; buf_wdata = 32'hDEAD;
            end else begin
                buf_we = 1'b0;
            end
            tick();
        end
        buf_we = 1'b0; qpi_next_word = 1'b0;
        #1 chk("t4_done", 32'(done), 32'd1);
        tick();
        buf_idx = 3'd2;
        #1 chk("t4_buf2_protected", buf_rdata, 32'hB2);
        qpi_next_word = 1'b1; qpi_rdata = 32'hFFFF_FFFF;
        tick();
        qpi_next_word = 1'b0;
        buf_idx = 3'd0;
        #1;
        chk("t4_stray_buf0", buf_rdata, 32'hB0);
        chk("t4_stray_ready", 32'(req_ready), 32'd1);
        chk("t4_stray_no_read", 32'(qpi_do_read), 32'd0);

        // ---------------- 5: reset in the 4th word ----------------
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000500;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            qpi_next_word = 1'b1; qpi_rdata = 32'hC0 + 32'(i);
            tick();
        end
        qpi_rdata = 32'hC3;
        #1 chk("t5_do_read_pre", 32'(qpi_do_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_do_read", 32'(qpi_do_read), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_qpi_addr", 32'(qpi_addr), 32'd0);
        buf_idx = 3'd1;
        #1 chk("t5_buf1_zero", buf_rdata, 32'd0);
        qpi_next_word = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000600;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < LW; i++) begin
            qpi_next_word = 1'b1; qpi_rdata = 32'hD0 + 32'(i);
            tick();
        end
        qpi_next_word = 1'b0;
        #1 chk("t5_new_done", 32'(done), 32'd1);
        tick();
        buf_idx = 3'd7;
        #1 chk("t5_new_buf7", buf_rdata, 32'hD7);

`ifdef QPI_BURST_TIMEOUT_EN
        // ---------------- 6: watchdog abort after 15 stall cycles ----------------
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000700;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            qpi_next_word = 1'b1; qpi_rdata = 32'hE0 + 32'(i);
            tick();
        end
        qpi_next_word = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1 chk("t6_stall_read", 32'(qpi_do_read), 32'd1);
            tick();
        end
        #1 chk("t6_abort_read", 32'(qpi_do_read), 32'd0);
        tick();
        #1;
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_err", 32'(err), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            buf_idx = 3'(i);
            #1 chk("t6_buf_kept", buf_rdata, 32'hE0 + 32'(i));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
